// File: rtl/gemm_pkg.sv
// Shared types for the GeMM output writer: FSM state encoding and tile address helper.
package gemm_pkg;

  typedef enum logic [1:0] {
    WriterIdle = 2'd0,
    WriterRun  = 2'd1,
    WriterDone = 2'd2
  } writer_state_t;

  // Row-major tile address: m-outer / n-inner, matching the controller's issue order.
  function automatic logic [31:0] tile_addr(input logic [31:0] m_tile,
                                            input logic [31:0] n_tile,
                                            input logic [31:0] tiles_n);
    return m_tile * tiles_n + n_tile;
  endfunction

endpackage

// File: rtl/gemm_result_fifo.sv
// Synchronous FIFO, registered head (no fall-through); push ignored when full, pop ignored when empty.
// Depth must be a power of two so the pointers wrap naturally; clr_i flushes without touching storage.
module gemm_result_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] FullCnt = Depth[PtrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/gemm_output_writer.sv
// GeMM result sink: buffers tiles from the PE array and writes them to output SRAM via req/gnt (req one cycle after accept).
// No backpressure upstream: tiles offered while not ready are dropped and flagged; GEMM_WRITER_PERF_EN adds a stall counter.
module gemm_output_writer
  import gemm_pkg::*;
#(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned M         = 4,
  parameter int unsigned N         = 4,
  parameter int unsigned OutWidth  = 32,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [AddrWidth-1:0]      M_size_i,
  input  logic [AddrWidth-1:0]      N_size_i,
  input  logic                      result_valid_i,
  input  logic [M*N*OutWidth-1:0]   result_data_i,
  output logic                      result_ready_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic [M*N*OutWidth-1:0]   mem_wdata_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overflow_o,
  output logic [AddrWidth-1:0]      tiles_written_o
`ifdef GEMM_WRITER_PERF_EN
  ,
  output logic [AddrWidth-1:0]      stall_cycles_o
`endif
);

  localparam int unsigned DataW = M * N * OutWidth;

  writer_state_t        state_q, state_d;
  logic [AddrWidth-1:0] tiles_n_q, total_q;
  logic [AddrWidth-1:0] accepted_q, written_q;
  logic [AddrWidth-1:0] m_tile_q, n_tile_q;
  logic                 overflow_q;

  logic [AddrWidth-1:0] start_tiles_m, start_tiles_n, start_total;
  logic                 start_job, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [DataW-1:0]     fifo_head;

  assign start_tiles_m = M_size_i / AddrWidth'(M);
  assign start_tiles_n = N_size_i / AddrWidth'(N);
  assign start_total   = start_tiles_m * start_tiles_n;

  assign start_job = (state_q == WriterIdle) && start_i;
  assign push      = result_valid_i && result_ready_o;
  assign mem_req_o = !fifo_empty;
  assign pop       = mem_req_o && mem_gnt_i;

  gemm_result_fifo #(
    .Width (DataW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (start_job),
    .push_i  (push),
    .data_i  (result_data_i),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (fifo_head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= WriterIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WriterIdle: if (start_i) state_d = (start_total == '0) ? WriterDone : WriterRun;
      WriterRun:  if (pop && ((written_q + 1'b1) == total_q)) state_d = WriterDone;
      WriterDone: state_d = WriterIdle;
      default:    state_d = WriterIdle;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != WriterIdle);
    done_o         = (state_q == WriterDone);
    result_ready_o = (state_q == WriterRun) && !fifo_full && (accepted_q < total_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tiles_n_q  <= '0;
      total_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      m_tile_q   <= '0;
      n_tile_q   <= '0;
      overflow_q <= 1'b0;
    end else if (start_job) begin
      tiles_n_q  <= start_tiles_n;
      total_q    <= start_total;
      accepted_q <= '0;
      written_q  <= '0;
      m_tile_q   <= '0;
      n_tile_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) accepted_q <= accepted_q + 1'b1;
      if ((state_q == WriterRun) && result_valid_i && !result_ready_o) overflow_q <= 1'b1;
      if (pop) begin
        written_q <= written_q + 1'b1;
        if (n_tile_q == tiles_n_q - 1'b1) begin
          n_tile_q <= '0;
          m_tile_q <= m_tile_q + 1'b1;
        end else begin
          n_tile_q <= n_tile_q + 1'b1;
        end
      end
    end
  end

  assign mem_addr_o      = AddrWidth'(tile_addr(32'(m_tile_q), 32'(n_tile_q), 32'(tiles_n_q)));
  assign mem_wdata_o     = fifo_head;
  assign overflow_o      = overflow_q;
  assign tiles_written_o = written_q;

`ifdef GEMM_WRITER_PERF_EN
  logic [AddrWidth-1:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (start_job) begin
      stall_q <= '0;
    end else if ((state_q == WriterRun) && mem_req_o && !mem_gnt_i && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
